// File: rtl/reg_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_alu_pkg
// Purpose  : Shared constants and types for the reg_alu instruction sequencer:
//            opcodes, instruction field positions, the control bundle and the
//            sequencer state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package reg_alu_pkg;

   localparam int C_DATA_W = 16;
   localparam int C_ADDR_W = 3;
   localparam int C_CNT_W  = 8;

   // Opcodes carried in instr[15:12]; 7..15 are illegal.
   localparam logic [3:0] OP_NOP = 4'd0;
   localparam logic [3:0] OP_LDI = 4'd1;
   localparam logic [3:0] OP_ALU = 4'd2;
   localparam logic [3:0] OP_SLL = 4'd3;
   localparam logic [3:0] OP_SRL = 4'd4;
   localparam logic [3:0] OP_SRA = 4'd5;
   localparam logic [3:0] OP_SLT = 4'd6;

   // Instruction field LSB positions. The shift amount [5:2] deliberately
   // overlaps rd_addr_b [5:3]: shifts only read operand A.
   localparam int OPC_LSB = 12;
   localparam int WA_LSB  = 9;
   localparam int RA_LSB  = 6;
   localparam int RB_LSB  = 3;
   localparam int SFT_LSB = 2;
   localparam int ALU_LSB = 0;

   // Full reg_alu control bundle; field order of the five selects matches
   // the {slt_sel, sel, main_sel, sft_sel, ryt_sft_sel} encoding table.
   typedef struct packed {
      logic                slt_sel;
      logic                sel;
      logic                main_sel;
      logic                sft_sel;
      logic                ryt_sft_sel;
      logic                wr;
      logic [1:0]          op;
      logic [3:0]          sft_op;
      logic [C_ADDR_W-1:0] rd_addr_a;
      logic [C_ADDR_W-1:0] rd_addr_b;
      logic [C_ADDR_W-1:0] wr_addr;
      logic [C_DATA_W-1:0] d_in;
   } ctrl_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_IMM  = 2'd1,
      ST_TRAP = 2'd2
   } state_t;

endpackage : reg_alu_pkg
`default_nettype wire

// File: rtl/reg_alu_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_alu_seq_if
// Purpose  : Instruction handshake plus reg_alu control bundle. The master is
//            the instruction source; the slave is the sequencer, which
//            consumes instructions and drives the reg_alu controls.
// Revision : 1.0 - initial release
// ============================================================================
interface reg_alu_seq_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3,
   parameter int CNT_W  = 8
);
   logic              instr_valid;
   logic [DATA_W-1:0] instr;
   logic              instr_ready;
   logic              slt_sel;
   logic              sel;
   logic              main_sel;
   logic              sft_sel;
   logic              ryt_sft_sel;
   logic              wr;
   logic [1:0]        op;
   logic [3:0]        sft_op;
   logic [ADDR_W-1:0] rd_addr_a;
   logic [ADDR_W-1:0] rd_addr_b;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] d_in;
   logic              busy;
   logic              err;
   logic [CNT_W-1:0]  issue_cnt;

   modport master (
      output instr_valid, instr,
      input  instr_ready, slt_sel, sel, main_sel, sft_sel, ryt_sft_sel, wr,
             op, sft_op, rd_addr_a, rd_addr_b, wr_addr, d_in, busy, err,
             issue_cnt
   );

   modport slave (
      input  instr_valid, instr,
      output instr_ready, slt_sel, sel, main_sel, sft_sel, ryt_sft_sel, wr,
             op, sft_op, rd_addr_a, rd_addr_b, wr_addr, d_in, busy, err,
             issue_cnt
   );
endinterface : reg_alu_seq_if
`default_nettype wire

// File: rtl/reg_alu_dec.sv
`default_nettype none
// ============================================================================
// Module   : reg_alu_dec
// Purpose  : Combinational decoder from an instruction (or LDI immediate) word
//            to the next reg_alu control bundle. Fields an instruction does
//            not own are carried over from the current bundle so they hold.
// Revision : 1.0 - initial release
// ============================================================================
module reg_alu_dec
   import reg_alu_pkg::*;
(
   input  wire logic [C_DATA_W-1:0] i_word,
   input  wire logic                i_imm,
   input  wire logic [C_ADDR_W-1:0] i_ldi_addr,
   input  wire ctrl_t               i_prev,
   output ctrl_t                    o_ctrl,
   output logic                     o_issue,
   output logic                     o_ldi,
   output logic                     o_illegal
);

   // Decode opcode to selects/fields and build the candidate control bundle.
   always_comb begin
      logic [3:0] w_opc;
      logic [4:0] w_sel;
      logic [1:0] w_op;
      logic [3:0] w_sft;
      logic       w_exec;

      w_opc     = i_word[OPC_LSB +: 4];
      w_sel     = 5'b00000;
      w_op      = 2'b00;
      w_sft     = 4'd0;
      w_exec    = 1'b0;
      o_ctrl    = i_prev;
      o_ctrl.wr = 1'b0;
      o_issue   = 1'b0;
      o_ldi     = 1'b0;
      o_illegal = 1'b0;

      if (i_imm) begin
         // Second LDI word: the whole word is write data.
         o_ctrl.slt_sel     = 1'b0;
         o_ctrl.sel         = 1'b0;
         o_ctrl.main_sel    = 1'b1;
         o_ctrl.sft_sel     = 1'b0;
         o_ctrl.ryt_sft_sel = 1'b0;
         o_ctrl.op          = 2'b00;
         o_ctrl.sft_op      = 4'd0;
         o_ctrl.wr_addr     = i_ldi_addr;
         o_ctrl.d_in        = i_word;
         o_ctrl.wr          = 1'b1;
         o_issue            = 1'b1;
      end else begin
         case (w_opc)
            OP_NOP: ;
            OP_LDI: o_ldi = 1'b1;
            OP_ALU: begin
               w_sel  = 5'b01000;
               w_op   = i_word[ALU_LSB +: 2];
               w_exec = 1'b1;
            end
            OP_SLL: begin
               w_sel  = 5'b01100;
               w_sft  = i_word[SFT_LSB +: 4];
               w_exec = 1'b1;
            end
            OP_SRL: begin
               w_sel  = 5'b01110;
               w_sft  = i_word[SFT_LSB +: 4];
               w_exec = 1'b1;
            end
            OP_SRA: begin
               w_sel  = 5'b01111;
               w_sft  = i_word[SFT_LSB +: 4];
               w_exec = 1'b1;
            end
            OP_SLT: begin
               w_sel  = 5'b11011;
               w_exec = 1'b1;
            end
            default: o_illegal = 1'b1;
         endcase

         if (w_exec) begin
            o_ctrl.slt_sel     = w_sel[4];
            o_ctrl.sel         = w_sel[3];
            o_ctrl.main_sel    = w_sel[2];
            o_ctrl.sft_sel     = w_sel[1];
            o_ctrl.ryt_sft_sel = w_sel[0];
            o_ctrl.op          = w_op;
            o_ctrl.sft_op      = w_sft;
            o_ctrl.wr_addr     = i_word[WA_LSB +: C_ADDR_W];
            o_ctrl.rd_addr_a   = i_word[RA_LSB +: C_ADDR_W];
            o_ctrl.rd_addr_b   = i_word[RB_LSB +: C_ADDR_W];
            o_ctrl.wr          = 1'b1;
            o_issue            = 1'b1;
         end
      end
   end

endmodule : reg_alu_dec
`default_nettype wire

// File: rtl/reg_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : reg_alu_seq
// Purpose  : Instruction sequencer for reg_alu. Accepts 16-bit words over a
//            valid/ready handshake and issues one registered control cycle
//            per instruction (latency 1, full throughput in IDLE). LDI takes
//            two words: opcode/destination, then the immediate.
// Config   : REG_ALU_SEQ_ILLEGAL_TRAP_EN - illegal opcodes lock the sequencer
//            in TRAP with sticky err until reset. Undefined: illegal opcodes
//            behave as NOP with a one-cycle err pulse.
// Revision : 1.0 - initial release
// ============================================================================
module reg_alu_seq
   import reg_alu_pkg::*;
#(
   parameter int DATA_W = C_DATA_W,
   parameter int ADDR_W = C_ADDR_W,
   parameter int CNT_W  = C_CNT_W
) (
   input  wire logic     clk,
   input  wire logic     reset,
   reg_alu_seq_if.slave  bus
);

   state_t            r_state;
   logic              r_ready;
   logic              r_busy;
   logic              r_err;
   logic [CNT_W-1:0]  r_cnt;
   logic [ADDR_W-1:0] r_ldi_addr;
   ctrl_t             r_ctrl;

   ctrl_t             w_ctrl;
   logic              w_issue;
   logic              w_ldi;
   logic              w_illegal;
   logic              w_accept;
   logic [DATA_W-1:0] w_word;

   localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   assign w_word   = bus.instr;
   assign w_accept = bus.instr_valid & r_ready;

   reg_alu_dec u_dec (
      .i_word     (w_word),
      .i_imm      (r_state == ST_IMM),
      .i_ldi_addr (r_ldi_addr),
      .i_prev     (r_ctrl),
      .o_ctrl     (w_ctrl),
      .o_issue    (w_issue),
      .o_ldi      (w_ldi),
      .o_illegal  (w_illegal)
   );

   // Sequencer FSM: owns handshake, issue registers, status and issue counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_ready    <= 1'b0;
         r_busy     <= 1'b0;
         r_err      <= 1'b0;
         r_cnt      <= '0;
         r_ldi_addr <= '0;
         r_ctrl     <= '0;
      end else begin
         // wr is a single-cycle strobe; every other control holds.
         r_ctrl.wr <= 1'b0;
`ifndef REG_ALU_SEQ_ILLEGAL_TRAP_EN
         r_err     <= 1'b0;
`endif
         case (r_state)
            ST_IDLE: begin
               r_ready <= 1'b1;
               r_busy  <= 1'b0;
               if (w_accept) begin
                  if (w_ldi) begin
                     r_ldi_addr <= w_word[WA_LSB +: ADDR_W];
                     r_state    <= ST_IMM;
                     r_busy     <= 1'b1;
                  end else if (w_illegal) begin
`ifdef REG_ALU_SEQ_ILLEGAL_TRAP_EN
                     r_state <= ST_TRAP;
                     r_ready <= 1'b0;
                     r_busy  <= 1'b1;
                     r_err   <= 1'b1;
`else
                     r_err   <= 1'b1;
`endif
                  end else if (w_issue) begin
                     r_ctrl <= w_ctrl;
                     r_cnt  <= r_cnt + c_CNT_ONE;
                  end
               end
            end
            ST_IMM: begin
               r_ready <= 1'b1;
               if (w_accept) begin
                  r_ctrl  <= w_ctrl;
                  r_cnt   <= r_cnt + c_CNT_ONE;
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            ST_TRAP: begin
               r_ready <= 1'b0;
               r_busy  <= 1'b1;
               r_err   <= 1'b1;
            end
            default: begin
               r_state <= ST_IDLE;
               r_ready <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.instr_ready = r_ready;
   assign bus.slt_sel     = r_ctrl.slt_sel;
   assign bus.sel         = r_ctrl.sel;
   assign bus.main_sel    = r_ctrl.main_sel;
   assign bus.sft_sel     = r_ctrl.sft_sel;
   assign bus.ryt_sft_sel = r_ctrl.ryt_sft_sel;
   assign bus.wr          = r_ctrl.wr;
   assign bus.op          = r_ctrl.op;
   assign bus.sft_op      = r_ctrl.sft_op;
   assign bus.rd_addr_a   = r_ctrl.rd_addr_a;
   assign bus.rd_addr_b   = r_ctrl.rd_addr_b;
   assign bus.wr_addr     = r_ctrl.wr_addr;
   assign bus.d_in        = r_ctrl.d_in;
   assign bus.busy        = r_busy;
   assign bus.err         = r_err;
   assign bus.issue_cnt   = r_cnt;

endmodule : reg_alu_seq
`default_nettype wire

// File: tb/tb_reg_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_alu_seq
// Purpose  : Directed self-checking bench for reg_alu_seq.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_alu_seq;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;

   reg_alu_seq_if #(.DATA_W(16), .ADDR_W(3), .CNT_W(8)) bus ();

   reg_alu_seq u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock with the given handshake inputs; returns 1 time unit after the edge.
   task automatic cyc(input logic v, input logic [15:0] w);
      bus.instr_valid = v;
      bus.instr       = w;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      bus.instr_valid = 1'b0;
      bus.instr = 16'h0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (bus.instr_ready !== 1'b0) begin n_errors++; $display("FAIL rst_ready: got %b expected 0", bus.instr_ready); end
      n_checks++; if (bus.wr !== 1'b0) begin n_errors++; $display("FAIL rst_wr: got %b expected 0", bus.wr); end
      n_checks++; if (bus.d_in !== 16'h0) begin n_errors++; $display("FAIL rst_d_in: got %h expected 0000", bus.d_in); end
      n_checks++; if (bus.issue_cnt !== 8'd0) begin n_errors++; $display("FAIL rst_cnt: got %0d expected 0", bus.issue_cnt); end
      n_checks++; if ({bus.busy, bus.err, bus.main_sel, bus.sel} !== 4'b0) begin n_errors++; $display("FAIL rst_status: got %b expected 0000", {bus.busy, bus.err, bus.main_sel, bus.sel}); end
      reset = 1'b1;
      cyc(1'b0, 16'h0);
      n_checks++; if (bus.instr_ready !== 1'b1) begin n_errors++; $display("FAIL post_rst_ready: got %b expected 1", bus.instr_ready); end
   endtask

   task automatic test_ldi();
      cyc(1'b1, 16'h1000);
      n_checks++; if (bus.busy !== 1'b1) begin n_errors++; $display("FAIL ldi_busy: got %b expected 1", bus.busy); end
      n_checks++; if (bus.wr !== 1'b0) begin n_errors++; $display("FAIL ldi_first_wr: got %b expected 0", bus.wr); end
      n_checks++; if (bus.instr_ready !== 1'b1) begin n_errors++; $display("FAIL ldi_imm_ready: got %b expected 1", bus.instr_ready); end
      cyc(1'b1, 16'h03FF);
      n_checks++; if ({bus.slt_sel, bus.sel, bus.main_sel, bus.sft_sel, bus.ryt_sft_sel} !== 5'b00100) begin n_errors++; $display("FAIL ldi_sel: got %b expected 00100", {bus.slt_sel, bus.sel, bus.main_sel, bus.sft_sel, bus.ryt_sft_sel}); end
      n_checks++; if (bus.wr !== 1'b1) begin n_errors++; $display("FAIL ldi_wr: got %b expected 1", bus.wr); end
      n_checks++; if (bus.wr_addr !== 3'd0) begin n_errors++; $display("FAIL ldi_wr_addr: got %0d expected 0", bus.wr_addr); end
      n_checks++; if (bus.d_in !== 16'h03FF) begin n_errors++; $display("FAIL ldi_d_in: got %h expected 03ff", bus.d_in); end
      n_checks++; if (bus.issue_cnt !== 8'd1) begin n_errors++; $display("FAIL ldi_cnt: got %0d expected 1", bus.issue_cnt); end
      n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL ldi_busy_done: got %b expected 0", bus.busy); end
      cyc(1'b0, 16'h0);
      n_checks++; if (bus.wr !== 1'b0) begin n_errors++; $display("FAIL ldi_wr_pulse: got %b expected 0", bus.wr); end
      n_checks++; if (bus.d_in !== 16'h03FF) begin n_errors++; $display("FAIL ldi_d_in_hold: got %h expected 03ff", bus.d_in); end
   endtask

   task automatic test_sll();
      cyc(1'b1, 16'h3288);
      bus.instr_valid = 1'b0;
      n_checks++; if ({bus.slt_sel, bus.sel, bus.main_sel, bus.sft_sel, bus.ryt_sft_sel} !== 5'b01100) begin n_errors++; $display("FAIL sll_sel: got %b expected 01100", {bus.slt_sel, bus.sel, bus.main_sel, bus.sft_sel, bus.ryt_sft_sel}); end
      n_checks++; if (bus.sft_op !== 4'd2) begin n_errors++; $display("FAIL sll_sft_op: got %0d expected 2", bus.sft_op); end
      n_checks++; if (bus.rd_addr_a !== 3'd2) begin n_errors++; $display("FAIL sll_rd_a: got %0d expected 2", bus.rd_addr_a); end
      n_checks++; if (bus.wr_addr !== 3'd1) begin n_errors++; $display("FAIL sll_wr_addr: got %0d expected 1", bus.wr_addr); end
      n_checks++; if (bus.op !== 2'd0) begin n_errors++; $display("FAIL sll_op: got %0d expected 0", bus.op); end
      n_checks++; if (bus.wr !== 1'b1) begin n_errors++; $display("FAIL sll_wr: got %b expected 1", bus.wr); end
      n_checks++; if (bus.d_in !== 16'h03FF) begin n_errors++; $display("FAIL sll_d_in_hold: got %h expected 03ff", bus.d_in); end
      cyc(1'b0, 16'h0);
      n_checks++; if (bus.wr !== 1'b0) begin n_errors++; $display("FAIL sll_wr_once: got %b expected 0", bus.wr); end
      n_checks++; if (bus.sft_op !== 4'd2) begin n_errors++; $display("FAIL sll_hold: got %0d expected 2", bus.sft_op); end
      n_checks++; if (bus.issue_cnt !== 8'd2) begin n_errors++; $display("FAIL sll_cnt: got %0d expected 2", bus.issue_cnt); end
   endtask

   task automatic test_back_to_back();
      cyc(1'b1, 16'h5314);
      n_checks++; if ({bus.sft_sel, bus.ryt_sft_sel, bus.sel, bus.main_sel} !== 4'b1111) begin n_errors++; $display("FAIL sra_sel: got %b expected 1111", {bus.sft_sel, bus.ryt_sft_sel, bus.sel, bus.main_sel}); end
      n_checks++; if (bus.sft_op !== 4'd5) begin n_errors++; $display("FAIL sra_sft_op: got %0d expected 5", bus.sft_op); end
      n_checks++; if (bus.rd_addr_a !== 3'd4) begin n_errors++; $display("FAIL sra_rd_a: got %0d expected 4", bus.rd_addr_a); end
      n_checks++; if (bus.wr !== 1'b1) begin n_errors++; $display("FAIL sra_wr: got %b expected 1", bus.wr); end
      cyc(1'b1, 16'h63D8);
      bus.instr_valid = 1'b0;
      n_checks++; if ({bus.slt_sel, bus.sel, bus.main_sel, bus.sft_sel, bus.ryt_sft_sel} !== 5'b11011) begin n_errors++; $display("FAIL slt_sel: got %b expected 11011", {bus.slt_sel, bus.sel, bus.main_sel, bus.sft_sel, bus.ryt_sft_sel}); end
      n_checks++; if ({bus.rd_addr_a, bus.rd_addr_b} !== {3'd7, 3'd3}) begin n_errors++; $display("FAIL slt_rd: got %0d/%0d expected 7/3", bus.rd_addr_a, bus.rd_addr_b); end
      n_checks++; if (bus.sft_op !== 4'd0) begin n_errors++; $display("FAIL slt_sft_op: got %0d expected 0", bus.sft_op); end
      n_checks++; if (bus.wr !== 1'b1) begin n_errors++; $display("FAIL slt_wr: got %b expected 1", bus.wr); end
      n_checks++; if (bus.issue_cnt !== 8'd4) begin n_errors++; $display("FAIL b2b_cnt: got %0d expected 4", bus.issue_cnt); end
   endtask

   task automatic test_alu_stream();
      logic [5:0] exp_wr;
      logic [5:0] got_wr;
      exp_wr = 6'b111101;
      got_wr = '0;
      for (int k = 0; k < 4; k++) begin
         cyc(1'b1, 16'h2A50 | 16'(k));
         got_wr[5-k] = bus.wr;
         chk("alu_op", 32'(bus.op), 32'(k));
      end
      n_checks++; if ({bus.sel, bus.main_sel, bus.wr_addr, bus.rd_addr_a, bus.rd_addr_b} !== {1'b1, 1'b0, 3'd5, 3'd1, 3'd2}) begin n_errors++; $display("FAIL alu_fields: got %b expected 1010100101 0", {bus.sel, bus.main_sel, bus.wr_addr, bus.rd_addr_a, bus.rd_addr_b}); end
      cyc(1'b0, 16'h2A52);
      got_wr[1] = bus.wr;
      cyc(1'b1, 16'h2A52);
      got_wr[0] = bus.wr;
      bus.instr_valid = 1'b0;
      n_checks++; if (got_wr !== exp_wr) begin n_errors++; $display("FAIL alu_wr_pattern: got %b expected %b", got_wr, exp_wr); end
      n_checks++; if (bus.issue_cnt !== 8'd9) begin n_errors++; $display("FAIL alu_cnt: got %0d expected 9", bus.issue_cnt); end
   endtask

   task automatic test_wrap();
      reset = 1'b0;
      cyc(1'b0, 16'h0);
      reset = 1'b1;
      cyc(1'b0, 16'h0);
      for (int k = 0; k < 255; k++) cyc(1'b1, 16'h2000);
      n_checks++; if (bus.issue_cnt !== 8'd255) begin n_errors++; $display("FAIL wrap_255: got %0d expected 255", bus.issue_cnt); end
      cyc(1'b1, 16'h2000);
      bus.instr_valid = 1'b0;
      n_checks++; if (bus.issue_cnt !== 8'd0) begin n_errors++; $display("FAIL wrap_0: got %0d expected 0", bus.issue_cnt); end
      n_checks++; if (bus.wr !== 1'b1) begin n_errors++; $display("FAIL wrap_wr: got %b expected 1", bus.wr); end
   endtask

   task automatic test_reset_mid_ldi();
      cyc(1'b0, 16'h0);
      cyc(1'b1, 16'h1200);
      bus.instr_valid = 1'b0;
      n_checks++; if (bus.busy !== 1'b1) begin n_errors++; $display("FAIL mid_ldi_busy: got %b expected 1", bus.busy); end
      reset = 1'b0;
      #2;
      n_checks++; if ({bus.busy, bus.instr_ready} !== 2'b00) begin n_errors++; $display("FAIL mid_ldi_async: got %b expected 00", {bus.busy, bus.instr_ready}); end
      @(posedge clk);
      #1;
      reset = 1'b1;
      cyc(1'b0, 16'h0);
      cyc(1'b1, 16'h0ABC);
      bus.instr_valid = 1'b0;
      n_checks++; if (bus.wr !== 1'b0) begin n_errors++; $display("FAIL mid_ldi_nop_wr: got %b expected 0", bus.wr); end
      n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL mid_ldi_nop_busy: got %b expected 0", bus.busy); end
      n_checks++; if (bus.d_in !== 16'h0) begin n_errors++; $display("FAIL mid_ldi_d_in: got %h expected 0000", bus.d_in); end
   endtask

   task automatic test_illegal();
      cyc(1'b0, 16'h0);
      cyc(1'b1, 16'hF000);
      n_checks++; if (bus.err !== 1'b1) begin n_errors++; $display("FAIL ill_err: got %b expected 1", bus.err); end
      n_checks++; if (bus.wr !== 1'b0) begin n_errors++; $display("FAIL ill_wr: got %b expected 0", bus.wr); end
`ifdef REG_ALU_SEQ_ILLEGAL_TRAP_EN
      n_checks++; if (bus.instr_ready !== 1'b0) begin n_errors++; $display("FAIL ill_ready: got %b expected 0", bus.instr_ready); end
      cyc(1'b1, 16'h2001);
      cyc(1'b1, 16'h2001);
      bus.instr_valid = 1'b0;
      n_checks++; if ({bus.err, bus.instr_ready, bus.wr, bus.busy} !== 4'b1001) begin n_errors++; $display("FAIL ill_sticky: got %b expected 1001", {bus.err, bus.instr_ready, bus.wr, bus.busy}); end
      reset = 1'b0;
      #2;
      n_checks++; if (bus.err !== 1'b0) begin n_errors++; $display("FAIL ill_clear: got %b expected 0", bus.err); end
      reset = 1'b1;
`else
      n_checks++; if (bus.instr_ready !== 1'b1) begin n_errors++; $display("FAIL ill_ready: got %b expected 1", bus.instr_ready); end
      cyc(1'b0, 16'h0);
      n_checks++; if ({bus.err, bus.wr, bus.busy} !== 3'b000) begin n_errors++; $display("FAIL ill_pulse: got %b expected 000", {bus.err, bus.wr, bus.busy}); end
`endif
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      test_reset();
      test_ldi();
      test_sll();
      test_back_to_back();
      test_alu_stream();
      test_wrap();
      test_reset_mid_ldi();
      test_illegal();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_reg_alu_seq
`default_nettype wire

// File: doc/reg_alu_seq.md
Name: reg_alu_seq

Overview:
- Instruction sequencer that drives the full control bundle of reg_alu: select lines, write enable, ALU op, shift amount, three register addresses and write data.
- Accepts 16-bit instruction words over a valid/ready handshake, decodes them, and issues one registered control cycle per instruction.
- Sits between an instruction source (ROM, host FIFO) and reg_alu, replacing hand-built test vectors as the initiator of reg_alu traffic.

Parameters:
- DATA_W, 16, width of d_in and instruction words
- ADDR_W, 3, register address width
- CNT_W, 8, width of issue counter

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- instr_valid  in  1  instruction word offered
- instr  in  DATA_W  instruction or immediate word
- instr_ready  out  1  word accepted on edge when instr_valid & instr_ready
- slt_sel, sel, main_sel, sft_sel, ryt_sft_sel, wr  out  1 each  reg_alu controls
- op  out  2  ALU op
- sft_op  out  4  shift amount
- rd_addr_a, rd_addr_b, wr_addr  out  ADDR_W  register addresses
- d_in  out  DATA_W  write data
- busy  out  1  state != IDLE
- err  out  1  illegal opcode indication
- issue_cnt  out  CNT_W  count of wr pulses issued

Behaviour:
- Instruction format: [15:12] opcode, [11:9] wr_addr, [8:6] rd_addr_a, [5:3] rd_addr_b, [5:2] shift amount, [1:0] ALU op.
- Opcodes: 0 NOP; 1 LDI (two-word); 2 ALU; 3 SLL; 4 SRL; 5 SRA; 6 SLT; 7-15 illegal.
- Select encodings, as {slt_sel, sel, main_sel, sft_sel, ryt_sft_sel}:
  - LDI 0,0,1,0,0
  - ALU 0,1,0,0,0 with op = instr[1:0]
  - SLL 0,1,1,0,0
  - SRL 0,1,1,1,0
  - SRA 0,1,1,1,1
  - SLT 1,1,0,1,1
- Non-issued fields: op = 0 except for ALU; sft_op = 0 except for shifts.
- All control outputs are registered. Latency is 1: an instruction accepted on edge N drives its controls with wr=1 in cycle N+1.
- wr is high for exactly one cycle per issued instruction. When nothing issues, wr=0 and every other control holds its last value.
- FSM states:
  - IDLE: instr_ready=1. Accepting a non-LDI instruction issues it. Accepting LDI latches wr_addr and moves to IMM, with no issue.
  - IMM: instr_ready=1. The next accepted word is the immediate: d_in = word, LDI selects applied, wr=1 next cycle, return to IDLE. No timeout.
  - TRAP: instr_ready=0. Entered only with the optional feature.
- Full throughput: in IDLE, back-to-back accepts issue on consecutive cycles. No hazard stall is needed, because reg_alu commits the write on the same edge that the next instruction's controls appear.
- NOP: accepted, no issue, controls hold.
- Illegal opcode: see Optional Feature.
- issue_cnt increments on every wr=1 cycle and wraps from 2^CNT_W-1 to 0.
- Reset (reset=0): state IDLE, instr_ready=0, all controls 0, d_in 0, busy 0, err 0, issue_cnt 0.
- Reset mid-LDI discards the pending immediate. The first word after reset is decoded as an opcode.

Optional Feature:
- Macro: REG_ALU_SEQ_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode moves the FSM to TRAP. err is sticky high and instr_ready stays 0 until reset. No issue occurs.
- Undefined: an illegal opcode is treated as NOP, err pulses high for one cycle (N+1), and the FSM stays in IDLE.

Decomposition:
- Shared package reg_alu_pkg holds:
  - opcode constants (OP_NOP..OP_SLT)
  - instruction field bit positions
  - a ctrl_t bundle typedef {slt_sel, sel, main_sel, sft_sel, ryt_sft_sel, wr, op, sft_op, rd_addr_a, rd_addr_b, wr_addr, d_in}
- One natural sub-module: reg_alu_dec, a combinational opcode-to-ctrl_t decoder. The parent owns the FSM, registers and counter.

Test Plan:
1. Reset, then LDI words 0x1000, 0x03FF -> one cycle after second accept: main_sel=1, sel=0, wr=1, wr_addr=0, d_in=0x03FF; busy=1 between words; issue_cnt=1.
2. 0x3288 (SLL r1,r2,2) -> sel=1, main_sel=1, sft_sel=0, ryt_sft_sel=0, sft_op=2, rd_addr_a=2, wr_addr=1, wr=1 for one cycle.
3. 0x5314 (SRA r1,r4,5), then 0x63D8 (SLT r1,r7,r3) back-to-back:
   - cycle 1: sft_sel=1, ryt_sft_sel=1, sft_op=5, rd_addr_a=4
   - cycle 2: slt_sel=1, sel=1, main_sel=0, rd_addr_a=7, rd_addr_b=3
   - wr high both cycles
4. Four ALU words with valid held, then valid low for one cycle, then one more -> wr pattern 1,1,1,1,0,1. Separately, 256 issues -> issue_cnt wraps to 0.
5. LDI opcode 0x1200, then reset pulse, then 0x0ABC -> after reset, 0x0ABC decodes as NOP: wr stays 0, busy=0.
6. 0xF000 -> with macro: err stuck 1, instr_ready=0 until reset. Without macro: err=1 for one cycle, instr_ready stays 1, no wr.
